// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Function : Round-robin arbiter that shares one memory refill port between
//            two cache controllers. The grant is held for a full line burst.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_cc2arb,
    input  logic [ADR_WIDTH-1:0]   adr0_cc2arb,
    input  logic                   req1_cc2arb,
    input  logic [ADR_WIDTH-1:0]   adr1_cc2arb,
    output logic                   ack_arb2cc0,
    output logic                   ack_arb2cc1,
    output logic [DATA_WIDTH-1:0]  dat_arb2cc,
    output logic [WORD_OFFSET-1:0] word_arb2cc,
    output logic                   req_arb2mem,
    output logic [ADR_WIDTH-1:0]   adr_arb2mem,
    input  logic                   ack_mem2arb,
    input  logic [DATA_WIDTH-1:0]  dat_mem2arb,
    output logic                   err_arb
);

    localparam logic [1:0]             c_IDLE      = 2'd0;
    localparam logic [1:0]             c_BURST     = 2'd1;
    localparam logic [1:0]             c_RELEASE   = 2'd2;
    localparam logic [WORD_OFFSET-1:0] c_LAST_BEAT = {WORD_OFFSET{1'b1}};

    logic [1:0]             r_state;
    logic                   r_grant;
    logic                   r_prio;
    logic [WORD_OFFSET-1:0] r_cnt;
    logic [ADR_WIDTH-1:0]   r_adr;

    logic [1:0]             w_state_nxt;
    logic                   w_grant_nxt;
    logic                   w_prio_nxt;
    logic [WORD_OFFSET-1:0] w_cnt_nxt;
    logic [ADR_WIDTH-1:0]   w_adr_nxt;
    logic                   w_sel;
    logic                   w_in_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
            r_adr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
            r_adr   <= w_adr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_adr_nxt   = r_adr;
        w_sel       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req0_cc2arb || req1_cc2arb) begin
                    // A lone requester wins outright; a tie goes to the favoured side.
                    w_sel       = (req0_cc2arb && req1_cc2arb) ? r_prio : req1_cc2arb;
                    w_grant_nxt = w_sel;
                    w_adr_nxt   = w_sel ? adr1_cc2arb : adr0_cc2arb;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                // Requests are ignored here: memory is committed to the whole line.
                if (ack_mem2arb) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_BEAT) begin
                        w_prio_nxt  = ~r_grant;
                        w_state_nxt = c_RELEASE;
                    end
                end
            end
            c_RELEASE: w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    assign w_in_burst  = (r_state == c_BURST);
    assign ack_arb2cc0 = w_in_burst & ack_mem2arb & ~r_grant;
    assign ack_arb2cc1 = w_in_burst & ack_mem2arb &  r_grant;
    assign dat_arb2cc  = dat_mem2arb;
    assign word_arb2cc = r_cnt;
    assign err_arb     = ack_mem2arb & ~w_in_burst;
    assign req_arb2mem = w_in_burst;
    assign adr_arb2mem = r_adr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Function : Directed self-checking bench for mem_arbiter with a beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, ack_mem;
    logic [31:0] adr0, adr1, dat_mem;
    logic        ack0, ack1, req_mem, err;
    logic [31:0] dat_cc, adr_mem;
    logic [1:0]  word;

    int total = 0;
    int bad   = 0;
    int owner_acks;

    typedef struct {
        int          owner;
        logic [1:0]  word;
        logic [31:0] data;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2)) dut (
        .clk(clk), .rst(rst),
        .req0_cc2arb(req0), .adr0_cc2arb(adr0),
        .req1_cc2arb(req1), .adr1_cc2arb(adr1),
        .ack_arb2cc0(ack0), .ack_arb2cc1(ack1),
        .dat_arb2cc(dat_cc), .word_arb2cc(word),
        .req_arb2mem(req_mem), .adr_arb2mem(adr_mem),
        .ack_mem2arb(ack_mem), .dat_mem2arb(dat_mem),
        .err_arb(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One acked memory beat; the expected routing is queued before it is driven.
    task automatic beat(input int owner, input logic [1:0] w, input logic [31:0] d);
        beat_t e, g;
        e.owner = owner; e.word = w; e.data = d;
        sb.push_back(e);
        ack_mem = 1'b1;
        dat_mem = d;
        @(negedge clk);
        if (ack0 ^ ack1) begin
            g = sb.pop_front();
            check("beat_owner", ack1 ? 64'd1 : 64'd0, g.owner);
            check("beat_word",  word,   g.word);
            check("beat_data",  dat_cc, g.data);
            if ((g.owner == 1) == ack1) owner_acks++;
        end else begin
            check("beat_ack_onehot", ack0 + ack1, 1);
        end
        check("beat_err", err, 0);
        tick();
        ack_mem = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        check("gap_ack0", ack0, 0);
        check("gap_ack1", ack1, 0);
        tick();
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!req_mem && n < 20) begin
            tick();
            n++;
        end
        check("grant_timeout", req_mem, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; ack_mem = 0;
        adr0 = '0; adr1 = '0; dat_mem = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_req", req_mem, 0);
        check("rst_adr", adr_mem, 0);
        check("rst_err", err, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_word", word, 0);
        tick();

        // Single requester, acks every other cycle
        req0 = 1; adr0 = 32'hFF07BD08;
        @(negedge clk);
        check("single_req_early", req_mem, 0);
        tick();
        check("single_req_lat", req_mem, 1);
        check("single_adr", adr_mem, 32'hFF07BD08);
        owner_acks = 0;
        for (int i = 0; i < 4; i++) begin
            gap();
            beat(0, 2'(i), 32'hFFFFFFFF);
        end
        req0 = 0;
        check("single_acks", owner_acks, 4);
        check("single_release", req_mem, 0);
        tick();

        // Simultaneous requests right after reset
        do_reset();
        req0 = 1; req1 = 1; adr0 = 32'hA5552D0C; adr1 = 32'hD500AD00;
        tick();
        check("simul_first_adr", adr_mem, 32'hA5552D0C);
        for (int i = 0; i < 4; i++) beat(0, 2'(i), 32'h1000 + i);
        req0 = 0;
        check("simul_release", req_mem, 0);
        tick();
        check("simul_idle", req_mem, 0);
        tick();
        check("simul_second_req", req_mem, 1);
        check("simul_second_adr", adr_mem, 32'hD500AD00);
        for (int i = 0; i < 4; i++) beat(1, 2'(i), 32'h2000 + i);
        req1 = 0;
        tick();

        // Fairness: both held high over four bursts
        req0 = 1; req1 = 1; adr0 = 32'h11110000; adr1 = 32'h22220000;
        for (int b = 0; b < 4; b++) begin
            wait_grant();
            check("fair_adr", adr_mem, (b % 2) ? 32'h22220000 : 32'h11110000);
            owner_acks = 0;
            for (int i = 0; i < 4; i++) beat(b % 2, 2'(i), 32'hC0DE0000 + 32'(b * 4 + i));
            check("fair_acks", owner_acks, 4);
        end
        req0 = 0; req1 = 0;
        tick();
        tick();

        // Requester 1 withdraws and changes address mid-burst
        req1 = 1; adr1 = 32'h33330040;
        wait_grant();
        beat(1, 2'd0, 32'h5A5A0000);
        beat(1, 2'd1, 32'h5A5A0001);
        req1 = 0; adr1 = 32'hDEADBEEF;
        @(negedge clk);
        check("wd_req_held", req_mem, 1);
        check("wd_adr_held", adr_mem, 32'h33330040);
        tick();
        beat(1, 2'd2, 32'h5A5A0002);
        check("wd_adr_held2", adr_mem, 32'h33330040);
        beat(1, 2'd3, 32'h5A5A0003);
        check("wd_release", req_mem, 0);
        tick();
        tick();

        // Stray ack in IDLE
        ack_mem = 1; dat_mem = 32'hBADBAD00;
        @(negedge clk);
        check("stray_err", err, 1);
        check("stray_ack0", ack0, 0);
        check("stray_ack1", ack1, 0);
        tick();
        ack_mem = 0;
        @(negedge clk);
        check("stray_err_once", err, 0);
        tick();

        // Reset after beat 1 of a requester-1 burst
        req1 = 1; adr1 = 32'h44440080;
        wait_grant();
        beat(1, 2'd0, 32'h77770000);
        beat(1, 2'd1, 32'h77770001);
        rst = 1; req1 = 0;
        tick();
        rst = 0;
        check("mrst_req", req_mem, 0);
        check("mrst_adr", adr_mem, 0);
        ack_mem = 1;
        @(negedge clk);
        check("mrst_err", err, 1);
        check("mrst_ack1", ack1, 0);
        tick();
        ack_mem = 0;
        req0 = 1; req1 = 1; adr0 = 32'h55550000; adr1 = 32'h66660000;
        tick();
        check("mrst_grant_req", req_mem, 1);
        check("mrst_grant_adr", adr_mem, 32'h55550000);
        for (int i = 0; i < 4; i++) beat(0, 2'(i), 32'h88880000 + i);
        req0 = 0; req1 = 0;
        tick();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory refill port between two cache controllers (instruction side = requester 0, data side = requester 1). It sits between the `req_cc2mem`/`adr_cc2mem`/`ack_mem2cc`/`dat_mem2cc` ports of each cacheController and the memory. It grants one requester at a time with round-robin fairness, holds the grant for a full line burst of 2^WORD_OFFSET acked beats, and routes acks and data back to the owner.

## Interface
- ADR_WIDTH, 32, address width
- DATA_WIDTH, 32, memory data word width
- WORD_OFFSET, 2, log2 of words per line; a burst is 2^WORD_OFFSET beats
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0_cc2arb  in  1  requester 0 refill request; held high through its burst
- adr0_cc2arb  in  ADR_WIDTH  requester 0 line address
- req1_cc2arb  in  1  requester 1 refill request
- adr1_cc2arb  in  ADR_WIDTH  requester 1 line address
- ack_arb2cc0  out  1  beat ack to requester 0
- ack_arb2cc1  out  1  beat ack to requester 1
- dat_arb2cc  out  DATA_WIDTH  beat data, shared by both requesters
- word_arb2cc  out  WORD_OFFSET  index of the beat currently acked
- req_arb2mem  out  1  request to memory
- adr_arb2mem  out  ADR_WIDTH  latched address of the granted requester
- ack_mem2arb  in  1  memory beat ack; one-cycle pulse per word
- dat_mem2arb  in  DATA_WIDTH  memory data, valid with ack_mem2arb
- err_arb  out  1  one-cycle pulse on a stray ack

## Operation
- Registers: state {IDLE, BURST, RELEASE}, grant (1 bit), prio (1 bit, the favoured requester), beat counter (WORD_OFFSET bits), latched address.
- IDLE, with neither req high: stay in IDLE.
- IDLE, with exactly one req high: grant that requester.
- IDLE, with both req high: grant = prio.
- On a grant: latch the granted requester's address into adr_arb2mem, clear the beat counter, go to BURST.
- BURST: req_arb2mem = 1.
- BURST, per ack_mem2arb: ack_arb2ccN = ack_mem2arb for the granted N only; the other requester's ack stays 0. dat_arb2cc = dat_mem2arb. word_arb2cc = beat counter. The counter increments after each ack.
- BURST, on the ack where the counter = 2^WORD_OFFSET-1: the counter wraps to 0, prio becomes ~grant, state goes to RELEASE.
- RELEASE: lasts one cycle with req_arb2mem = 0 (memory sees request deassert between bursts), then go to IDLE.
- Granted requester drops req mid-burst: the grant is kept and the burst still completes, because memory is committed. Remaining acks are still forwarded. The address does not change.
- Requester changes its address mid-burst: ignored; the latched address is used.
- ack_mem2arb while in IDLE or RELEASE: not forwarded; err_arb pulses 1 the same cycle.
- Non-granted requester asserting req during BURST: it waits. It wins the next arbitration because prio flips.

## Timing
- Reset values: state=IDLE, prio=0, grant=0, counter=0, req_arb2mem=0, adr_arb2mem=0, err_arb=0, both acks=0. word_arb2cc=0 and dat_arb2cc follow their definitions.
- Reset mid-burst: all registers return to the values above on the next edge. Later acks from memory pulse err_arb.
- Grant latency: req sampled high in IDLE at edge N, req_arb2mem high from edge N+1.
- Outputs are combinational from inputs and state with zero latency: ack_arb2ccN, dat_arb2cc, word_arb2cc, err_arb.
- Outputs decoded from registers: req_arb2mem, adr_arb2mem.
- Back-to-back bursts: last ack at edge M, RELEASE in cycle M+1, IDLE at M+2, next req_arb2mem high from M+3 at the earliest.
- Ack spacing is arbitrary, down to consecutive cycles. Each high cycle of ack_mem2arb counts as one beat.

## Test plan
- Single requester: req0=1, adr0=0xFF07BD08, four acks with data 0xFFFFFFFF spaced 2 cycles.
  - Required: req_arb2mem high 1 cycle after req0; adr_arb2mem=0xFF07BD08.
  - Required: ack_arb2cc0 pulses four times with word_arb2cc 0,1,2,3; ack_arb2cc1 stays 0.
  - Required: req_arb2mem low one cycle after the 4th ack.
- Simultaneous requests after reset: req0=req1=1, adr0=0xA5552D0C, adr1=0xD500AD00.
  - Required: requester 0 is served first, then requester 1 with adr_arb2mem=0xD500AD00.
  - Required: exactly one RELEASE cycle with req_arb2mem=0 between the two bursts.
- Fairness: both requesters held high for four bursts.
  - Required: grant order is 0,1,0,1.
  - Required: each burst delivers exactly 4 acks to its owner.
- Requester withdraws mid-burst: req1 deasserts after its 2nd ack.
  - Required: req_arb2mem stays high until the 4th ack; beats 2 and 3 still go to ack_arb2cc1.
  - Required: adr_arb2mem is unchanged throughout.
- Stray ack and reset: ack_mem2arb pulse in IDLE; separately, rst asserted after beat 1.
  - Required: err_arb=1 for exactly one cycle; no requester ack.
  - Required after reset: req_arb2mem=0, the next grant goes to requester 0, and a new burst restarts at word_arb2cc=0.
